riscv_multicycle_controller: RTL and testbench
==============================================

# riscv_multicycle_controller

Moore-style main controller for the multi-cycle RISC-V core. It sequences a single shared ALU, memory port and register file through fetch, decode, execute, memory and writeback states. It decodes `op`/`func3`/`func7` into per-state datapath controls and counts retired instructions. It sits beside the multi-cycle datapath and replaces the combinational main and ALU decoders used in the pipelined core.

## Interface
Parameters:
- `CNT_W`, 32: width of retired-instruction counter.

Ports:
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op` input 7: IR[6:0].
- `func3` input 3: IR[14:12].
- `func7` input 1: IR[30].
- `zero` input 1: ALU result == 0, same cycle.
- `PCWrite` output 1: PC load strobe.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = result bus.
- `MemWrite` output 1: data memory write strobe.
- `IRWrite` output 1: loads IR and oldPC.
- `RegWrite` output 1: register file write strobe.
- `ResultSrc` output 2: result bus select; 00 = ALUOut, 01 = mem data, 10 = ALU result, 11 = immediate.
- `ALUSrcA` output 2: ALU A select; 00 = PC, 01 = oldPC, 10 = rs1 register A.
- `ALUSrcB` output 2: ALU B select; 00 = register B, 01 = immediate, 10 = constant 4.
- `ImmSrc` output 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `ALUControl` output 3: 000 = add, 001 = sub, 010 = and, 011 = or, 100 = slt, 101 = sltu, 110 = xor.
- `illegal` output 1: sticky, set on an unsupported opcode.
- `instret` output CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRPC, LUI, ILLEGAL.
- Any control not listed for a state is 0.

Per-state outputs and next state:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. ImmSrc=011 if op=1101111, else 010. Next by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=000 for op=0000011, 001 for op=0100011. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00. PCWrite = taken. Next: FETCH.
  - beq(000): sub, taken = zero.
  - bne(001): sub, taken = !zero.
  - blt(100): slt, taken = !zero.
  - bge(101): slt, taken = zero.
  - Other func3: never taken.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add. Next: JALRPC.
- JALRPC: same as JAL. Next: ALUWB.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next: FETCH.
- ILLEGAL: all strobes 0, `illegal`=1. Held until `rst`.

ALU decode, applied in EXECR/EXECI by func3:
- 000: add. EXECR with func7=1 gives sub; EXECI ignores func7.
- 010: slt.
- 011: sltu.
- 100: xor.
- 110: or.
- 111: and.
- Others: add.

Other rules:
- `instret` increments by 1, wrapping modulo 2^CNT_W, on every clock edge where the next state is FETCH and the current state is not FETCH.
- JALR does not clear the target LSB.

## Timing
- Reset (asynchronous): state=FETCH, instret=0, illegal=0.
- While `rst`=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The first fetch happens on the first edge after `rst` deasserts.
- All outputs except the BRANCH PCWrite are pure functions of the registered state plus IR fields. BRANCH PCWrite also depends combinationally on `zero` in the same cycle.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type / I-type ALU: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - lui: 3
- `rst` asserted mid-instruction aborts it immediately. No partial strobe may occur after the reset edge.

## Test plan
- Reset: hold `rst` 3 cycles, then release → state FETCH, instret=0, every strobe 0 during reset, IRWrite=1 in the first cycle after release.
- add (op=0110011, func3=000, func7=0) → states FETCH, DECODE, EXECR, ALUWB. ALUControl=000 in EXECR, RegWrite=1 only in cycle 4, instret=1 after.
- lw then sw → 5 then 4 cycles. AdrSrc=1 in MEMREAD/MEMWRITE, MemWrite=1 exactly one cycle, instret=2.
- beq with zero=1, then bne with zero=1 → PCWrite=1 in BRANCH for beq, 0 for bne. Each takes 3 cycles.
- jal, jalr, lui → 4, 5 and 3 cycles. ImmSrc=011 in DECODE for jal, 100 in LUI. PCWrite=1 in JAL and JALRPC.
- op=1111111 → illegal=1 from the cycle after DECODE, no strobes for 10 cycles, instret unchanged. A `rst` pulse clears illegal.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Main controller for the multi-cycle RISC-V core.
// Sequences the shared ALU, memory port and register file through
// fetch/decode/execute/memory/writeback. It also decodes op/func3/func7
// into datapath selects and counts retired instructions.
module riscv_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // Opcodes recognised in DECODE
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result bus selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI,
        S_ILLEGAL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;

    // Raw strobes before the reset gate
    logic pc_write_c, mem_write_c, ir_write_c, reg_write_c;

    // Arithmetic/logic operation for EXECR/EXECI; only R-type honours func7 for sub
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7,
                                              input logic       is_rtype);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (is_rtype && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Branch compare op and taken decision; blt/bge use slt so zero means "not less"
    function automatic logic [3:0] branch_decode(input logic [2:0] f3,
                                                 input logic       z);
        logic [2:0] ctl;
        logic       taken;
        case (f3)
            3'b000:  begin ctl = ALU_SUB; taken = z;    end
            3'b001:  begin ctl = ALU_SUB; taken = !z;   end
            3'b100:  begin ctl = ALU_SLT; taken = !z;   end
            3'b101:  begin ctl = ALU_SLT; taken = z;    end
            default: begin ctl = ALU_ADD; taken = 1'b0; end
        endcase
        return {ctl, taken};
    endfunction

    // State, retire counter and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRNCH:          state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRPC;
            S_JALRPC:   state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Retire on every return to FETCH; illegal latches once the trap state is entered
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            instret_d = instret_q + CNT_W'(1);
        end
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    // Per-state datapath controls (Moore, except BRANCH PCWrite which follows zero)
    always_comb begin
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_REG;
        ImmSrc      = IMM_I;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
            end
            S_DECODE: begin
                // Precompute oldPC + imm as the branch/jal target
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc   = RES_MEM;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                ResultSrc   = RES_ALUOUT;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_REG;
                ALUControl = alu_decode(func3, func7, 1'b1);
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = alu_decode(func3, func7, 1'b0);
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA                  = SRCA_RS1;
                ALUSrcB                  = SRCB_REG;
                ResultSrc                = RES_ALUOUT;
                {ALUControl, pc_write_c} = branch_decode(func3, zero);
            end
            S_JAL, S_JALRPC: begin
                // Redirect PC to ALUOut while computing the link value oldPC + 4
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                pc_write_c = 1'b1;
            end
            S_JALR: begin
                // Target is rs1 + imm with the LSB left as computed
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
            end
            S_LUI: begin
                ImmSrc      = IMM_U;
                ResultSrc   = RES_IMM;
                reg_write_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Architectural strobes are suppressed for the whole reset interval
    assign PCWrite  = pc_write_c  & ~rst;
    assign MemWrite = mem_write_c & ~rst;
    assign IRWrite  = ir_write_c  & ~rst;
    assign RegWrite = reg_write_c & ~rst;
    assign illegal  = illegal_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller. Each issued
// instruction expands into its expected per-cycle control vectors; a
// negedge monitor pops and compares one vector per cycle.
module tb_riscv_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    op = 7'd0;
    logic [2:0]    func3 = 3'd0;
    logic          func7 = 1'b0;
    logic          zero = 1'b0;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]    ImmSrc, ALUControl;
    logic [CW-1:0] instret;

    riscv_multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] ctl;
        logic        ill;
        logic [3:0]  cnt;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_inst = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Control vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
    function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
    endfunction

    // ALU op from func3 for R/I arithmetic (add=0 sub=1 and=2 or=3 slt=4 sltu=5 xor=6)
    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [2:0] tbl [8];
        logic [2:0] r;
        tbl = '{3'd0, 3'd0, 3'd4, 3'd5, 3'd6, 3'd0, 3'd3, 3'd2};
        r = tbl[f3];
        if (f3 == 3'd0 && is_r && f7) r = 3'd1;
        return r;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    task automatic push(input logic [16:0] c, input logic ill, input logic [7:0] tag);
        exp_t e;
        e.ctl = c;
        e.ill = ill;
        e.cnt = 4'(m_inst);
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Expand one instruction into its cycle-by-cycle controls and run it to completion
    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        int          n0, n;
        logic [16:0] aluwb, jalv;
        logic [2:0]  balu;
        logic        tk;
        op = o; func3 = f3; func7 = f7; zero = z;
        n0 = sb_q.size();
        aluwb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
        jalv  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0);
        push(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0), 1'b0, 8'd0);
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1,
                (o == 7'b1101111) ? 3'd3 : 3'd2, 3'd0), 1'b0, 8'd1);
        case (o)
            7'b0000011: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0), 1'b0, 8'd2);
                push(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0, 8'd3);
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0, 8'd4);
            end
            7'b0100011: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0), 1'b0, 8'd2);
                push(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), 1'b0, 8'd3);
            end
            7'b0110011: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0, ref_alu(f3, f7, 1'b1)), 1'b0, 8'd2);
                push(aluwb, 1'b0, 8'd3);
            end
            7'b0010011: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, ref_alu(f3, f7, 1'b0)), 1'b0, 8'd2);
                push(aluwb, 1'b0, 8'd3);
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  begin balu = 3'd1; tk = z;    end
                    3'b001:  begin balu = 3'd1; tk = !z;   end
                    3'b100:  begin balu = 3'd4; tk = !z;   end
                    3'b101:  begin balu = 3'd4; tk = z;    end
                    default: begin balu = 3'd0; tk = 1'b0; end
                endcase
                push(mk(tk, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0, balu), 1'b0, 8'd2);
            end
            7'b1101111: begin
                push(jalv, 1'b0, 8'd2);
                push(aluwb, 1'b0, 8'd3);
            end
            7'b1100111: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0), 1'b0, 8'd2);
                push(jalv, 1'b0, 8'd3);
                push(aluwb, 1'b0, 8'd4);
            end
            7'b0110111: begin
                push(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 3'd4, 3'd0), 1'b0, 8'd2);
            end
            default: begin
                for (int i = 0; i < 10; i++) push(17'd0, 1'b1, 8'(2 + i));
            end
        endcase
        if (is_legal(o)) m_inst++;
        n = sb_q.size() - n0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; rst is raised asynchronously mid-cycle
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        sb_q.delete();
        m_inst = 0;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: during reset only quiescence is required; otherwise one vector per cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
            chk("rst_instret", 32'(instret), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
        end else if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("ctl[op=%b f3=%0d cyc=%0d]", op, func3, e.tag),
                32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ImmSrc, ALUControl}), 32'(e.ctl));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("instret", 32'(instret), 32'(e.cnt));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal_ops [8];
        logic [6:0] o;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        @(posedge clk);
        #1;
        do_reset(3);

        // Directed sequence
        issue(7'b0110011, 3'b000, 1'b0, 1'b0);  // add
        issue(7'b0110011, 3'b000, 1'b1, 1'b0);  // sub
        issue(7'b0000011, 3'b010, 1'b0, 1'b0);  // lw
        issue(7'b0100011, 3'b010, 1'b0, 1'b0);  // sw
        issue(7'b1100011, 3'b000, 1'b0, 1'b1);  // beq taken
        issue(7'b1100011, 3'b001, 1'b0, 1'b1);  // bne not taken
        issue(7'b1100011, 3'b100, 1'b0, 1'b0);  // blt taken
        issue(7'b1100011, 3'b101, 1'b0, 1'b0);  // bge not taken
        issue(7'b1100011, 3'b010, 1'b0, 1'b1);  // unsupported branch func3
        issue(7'b1101111, 3'b000, 1'b0, 1'b0);  // jal
        issue(7'b1100111, 3'b000, 1'b0, 1'b0);  // jalr
        issue(7'b0110111, 3'b000, 1'b0, 1'b0);  // lui
        issue(7'b0010011, 3'b000, 1'b1, 1'b0);  // addi ignores func7
        issue(7'b1111111, 3'b000, 1'b0, 1'b0);  // illegal
        do_reset(2);

        // Abort a load mid-flight: reset clears the count and no strobes leak
        op = 7'b0000011; func3 = 3'b010; func7 = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(1);

        // Randomized stream, with the counter wrapping and occasional illegal ops
        for (int k = 0; k < 70; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do o = 7'($urandom); while (is_legal(o));
                issue(o, 3'($urandom), 1'($urandom), 1'($urandom));
                do_reset($urandom_range(1, 3));
            end else begin
                issue(legal_ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
